rd_stream_if: RTL and testbench
===============================

Name: rd_stream_if

Overview:
Read-domain consumer stage that sits directly downstream of the async FIFO read pointer and its memory read port. It turns the FIFO's empty/rd_en/rdata interface into a valid/ready stream, prefetching into a 3-entry skid buffer. This hides the one-cycle memory read latency and sustains one word per cycle with no combinational path from m_ready to rd_en. A synchronous flush discards all buffered and in-flight words.

Parameters:
Data_Width, 8, width of FIFO read data and stream data

Ports:
rdclk  input  1  read-domain clock; all logic on posedge
rd_rst  input  1  synchronous, active-high reset; sampled on posedge rdclk
empty  input  1  FIFO empty flag from the read pointer block
rdata  input  Data_Width  FIFO memory read data; registered read port, valid the cycle after a fetch
rd_en  output  1  read request to the read pointer block and memory
flush  input  1  synchronous discard of buffered and in-flight data
m_valid  output  1  stream data valid
m_ready  input  1  downstream accepts m_data
m_data  output  Data_Width  stream data, head of the skid buffer
buf_cnt  output  2  number of words held in the skid buffer (0..3)

Behaviour:
- Reset (rd_rst=1 at posedge): cnt=0, inflight=0, head/tail ptrs=0, buffer regs=0. Outputs: m_valid=0, m_data=0, buf_cnt=0. rd_en=0 while rd_rst=1.
- fetch = rd_en & !empty. This is the actual read, consistent with the read pointer's gating of rd_en by !empty.
- rd_en = !rd_rst & !flush & ((cnt + inflight) < 3). It is combinational from registered state only and is independent of m_ready and empty. rd_en asserted while empty=1 is harmless and produces no fetch.
- inflight <= fetch. When inflight=1, rdata is written to buffer[tail] at the next posedge, and tail advances mod 3.
- pop = m_valid & m_ready. On pop, head advances mod 3.
- cnt_next = cnt + inflight - pop. Push and pop in the same cycle leave cnt unchanged. cnt never exceeds 3; the rd_en rule guarantees this.
- m_valid = (cnt != 0). m_data = buffer[head]. buf_cnt = cnt. All come directly from registers.
- Stability: while m_valid=1 and m_ready=0, m_data and m_valid hold.
- Latency: empty falls in cycle t with buffer space available:
  - rd_en=1 and fetch occur in cycle t;
  - data is captured at the end of t+1;
  - m_valid=1 in t+2.
- Throughput: steady state with !empty and m_ready=1 gives cnt+inflight=2, so fetch, capture and pop happen every cycle (1 word/cycle).
- Backpressure: with m_ready=0, fetching stops once cnt+inflight=3. In-flight data always has a slot.
- flush=1 at posedge:
  - cnt=0, head=tail=0, inflight=0;
  - a word arriving in that cycle (inflight=1) is discarded;
  - rd_en=0 in the flush cycle, so no word arrives afterwards from pre-flush fetches;
  - m_valid=0 from the next cycle.
  - flush overrides simultaneous pop and push. rd_rst overrides flush.
- Pointer wrap: head/tail count 0,1,2,0. The FIFO address and gray wrap live entirely in the read pointer block.
- Reset or flush mid-stream: the FIFO read pointer is not rewound. Discarded words are consumed from the FIFO.

Optional Feature:
RD_STREAM_WCNT_EN
- Defined: adds output port wcnt (16 bits). It counts accepted stream words (pop) and wraps 16'hFFFF -> 0. It is cleared to 0 by rd_rst and by flush; a pop in a flush cycle is not counted.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
1. Reset with empty=1 → rd_en=0 during reset. After reset: m_valid=0, buf_cnt=0, m_data=0. rd_en=1 while empty=1, with no capture.
2. Latency: FIFO holds 8'hA5, empty falls in cycle 0, m_ready=1 → rd_en=1 in cycle 0; m_valid=1 with m_data=8'hA5 in cycle 2; m_valid=0 in cycle 3.
3. Streaming: FIFO preloaded with 0x01..0x10, m_ready=1 → after 2-cycle fill, 16 consecutive m_valid cycles with data 0x01..0x10 in order and no gaps.
4. Backpressure: m_ready=0 with FIFO holding 10 words → exactly 3 fetches, buf_cnt=3, rd_en=0. Raising m_ready → all 10 words delivered in order with none lost or duplicated.
5. Flush with buf_cnt=2 and inflight=1 → next cycle: m_valid=0, buf_cnt=0; the in-flight word never appears. The next FIFO word is delivered first after the flush.
6. (RD_STREAM_WCNT_EN) Deliver 70000 words → wcnt=70000 mod 65536=4464. Flush → wcnt=0.

Source files
------------

// File: rtl/rd_stream_if.sv
//------------------------------------------------------------------------------
// Module  : rd_stream_if
// Brief   : Async-FIFO read-side adapter turning empty/rd_en/rdata into a
//           valid/ready stream via a 3-entry prefetch skid buffer.
//           Optional RD_STREAM_WCNT_EN adds a 16-bit accepted-word counter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rd_stream_if #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  rdclk,
    input  logic                  rd_rst,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rd_en,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            buf_cnt
`ifdef RD_STREAM_WCNT_EN
    ,
    output logic [15:0]           wcnt
`endif
);

    logic [1:0]            r_cnt;
    logic [1:0]            r_head;
    logic [1:0]            r_tail;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_buf [0:2];

    logic [2:0]            w_occ;
    logic                  w_fetch;
    logic                  w_pop;

    function automatic logic [1:0] f_inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Counting the in-flight word reserves its slot before it lands.
    assign w_occ   = {1'b0, r_cnt} + {2'b00, r_inflight};
    assign rd_en   = ~rd_rst & ~flush & (w_occ < 3'd3);
    assign w_fetch = rd_en & ~empty;
    assign m_valid = (r_cnt != 2'd0);
    assign w_pop   = m_valid & m_ready;
    assign buf_cnt = r_cnt;

    always_comb begin
        m_data = r_buf[0];
        case (r_head)
            2'd1:    m_data = r_buf[1];
            2'd2:    m_data = r_buf[2];
            default: m_data = r_buf[0];
        endcase
    end

    always_ff @(posedge rdclk) begin
        if (rd_rst) begin
            r_cnt      <= 2'd0;
            r_head     <= 2'd0;
            r_tail     <= 2'd0;
            r_inflight <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_buf[i] <= '0;
            end
        end else if (flush) begin
            r_cnt      <= 2'd0;
            r_head     <= 2'd0;
            r_tail     <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_fetch;
            if (r_inflight) begin
                case (r_tail)
                    2'd1:    r_buf[1] <= rdata;
                    2'd2:    r_buf[2] <= rdata;
                    default: r_buf[0] <= rdata;
                endcase
                r_tail <= f_inc3(r_tail);
            end
            if (w_pop) begin
                r_head <= f_inc3(r_head);
            end
            r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

`ifdef RD_STREAM_WCNT_EN
    logic [15:0] r_wcnt;

    always_ff @(posedge rdclk) begin
        if (rd_rst || flush) begin
            r_wcnt <= 16'd0;
        end else if (w_pop) begin
            r_wcnt <= r_wcnt + 16'd1;
        end
    end

    assign wcnt = r_wcnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rd_stream_if.sv
//------------------------------------------------------------------------------
// Module  : tb_rd_stream_if
// Brief   : Directed self-checking bench for rd_stream_if with a registered-read
//           FIFO model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rd_stream_if;

    logic        rdclk;
    logic        rd_rst;
    logic        empty;
    logic [7:0]  rdata;
    logic        rd_en;
    logic        flush;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic [1:0]  buf_cnt;
`ifdef RD_STREAM_WCNT_EN
    logic [15:0] wcnt;
`endif

    int n_vec;
    int n_err;

    // FIFO model: stimulus owns n_push and mem, the read process owns n_pop.
    logic [7:0] mem [0:79999];
    int         n_push;
    int         n_pop;

    rd_stream_if #(.DATA_WIDTH(8)) dut (
        .rdclk   (rdclk),
        .rd_rst  (rd_rst),
        .empty   (empty),
        .rdata   (rdata),
        .rd_en   (rd_en),
        .flush   (flush),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .buf_cnt (buf_cnt)
`ifdef RD_STREAM_WCNT_EN
        ,
        .wcnt    (wcnt)
`endif
    );

    initial rdclk = 1'b0;
    always #5 rdclk = ~rdclk;

    assign empty = (n_push == n_pop);

    initial begin
        n_pop = 0;
        rdata = 8'h00;
    end

    always @(posedge rdclk) begin
        if (rd_en && !empty) begin
            rdata <= mem[n_pop];
            n_pop <= n_pop + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[n_push] = d;
        n_push      = n_push + 1;
    endtask

    // Caller is positioned #1 after a negedge with m_ready already set.
    task automatic expect_stream(input string tag, input logic [7:0] first, input int n);
        int         got;
        int         guard;
        logic [7:0] e;
        got   = 0;
        guard = 0;
        e     = first;
        while (got < n && guard < n + 30) begin
            if (m_valid && m_ready) begin
                check(tag, {24'd0, m_data}, {24'd0, e});
                e   = e + 8'd1;
                got = got + 1;
            end
            @(negedge rdclk);
            #1;
            guard = guard + 1;
        end
        check({tag, "_count"}, got, n);
    endtask

    initial begin
        int g;
        int base;
        n_vec   = 0;
        n_err   = 0;
        n_push  = 0;
        rd_rst  = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b0;

        // Reset with empty FIFO
        repeat (3) @(negedge rdclk);
        #1;
        check("rst_rden", {31'd0, rd_en}, 32'd0);
        @(negedge rdclk);
        rd_rst = 1'b0;
        #1;
        check("rst_valid", {31'd0, m_valid}, 32'd0);
        check("rst_bufcnt", {30'd0, buf_cnt}, 32'd0);
        check("rst_data", {24'd0, m_data}, 32'd0);
        check("idle_rden", {31'd0, rd_en}, 32'd1);
`ifdef RD_STREAM_WCNT_EN
        check("rst_wcnt", {16'd0, wcnt}, 32'd0);
`endif
        repeat (3) @(negedge rdclk);
        #1;
        check("idle_bufcnt", {30'd0, buf_cnt}, 32'd0);
        check("idle_valid", {31'd0, m_valid}, 32'd0);
        check("idle_nofetch", n_pop, 32'd0);

        // Single-word latency
        @(negedge rdclk);
        m_ready = 1'b1;
        push(8'hA5);
        #1;
        check("lat_rden_c0", {31'd0, rd_en}, 32'd1);
        @(negedge rdclk);
        #1;
        check("lat_valid_c1", {31'd0, m_valid}, 32'd0);
        @(negedge rdclk);
        #1;
        check("lat_valid_c2", {31'd0, m_valid}, 32'd1);
        check("lat_data_c2", {24'd0, m_data}, 32'hA5);
        @(negedge rdclk);
        #1;
        check("lat_valid_c3", {31'd0, m_valid}, 32'd0);

        // Full-rate streaming
        @(negedge rdclk);
        for (int i = 1; i <= 16; i++) push(i[7:0]);
        #1;
        g = 0;
        while (!m_valid && g < 6) begin
            @(negedge rdclk);
            #1;
            g = g + 1;
        end
        check("stream_fill", g, 32'd2);
        for (int i = 1; i <= 16; i++) begin
            check("stream_valid", {31'd0, m_valid}, 32'd1);
            check("stream_data", {24'd0, m_data}, i);
            @(negedge rdclk);
            #1;
        end
        check("stream_end", {31'd0, m_valid}, 32'd0);

        // Backpressure
        @(negedge rdclk);
        m_ready = 1'b0;
        base    = n_pop;
        for (int i = 0; i < 10; i++) push(8'h40 + i[7:0]);
        repeat (6) @(negedge rdclk);
        #1;
        check("bp_bufcnt", {30'd0, buf_cnt}, 32'd3);
        check("bp_rden", {31'd0, rd_en}, 32'd0);
        check("bp_fetches", n_pop - base, 32'd3);
        check("bp_hold_data", {24'd0, m_data}, 32'h40);
        @(negedge rdclk);
        m_ready = 1'b1;
        #1;
        expect_stream("bp_data", 8'h40, 10);
        check("bp_drained", {30'd0, buf_cnt}, 32'd0);

        // Flush with two buffered words and one in flight
        @(negedge rdclk);
        m_ready = 1'b0;
        base    = n_pop;
        for (int i = 0; i < 6; i++) push(8'h31 + i[7:0]);
        @(negedge rdclk);
        @(negedge rdclk);
        @(negedge rdclk);
        flush = 1'b1;
        #1;
        check("fl_pre_bufcnt", {30'd0, buf_cnt}, 32'd2);
        check("fl_pre_fetches", n_pop - base, 32'd3);
        check("fl_rden", {31'd0, rd_en}, 32'd0);
        @(negedge rdclk);
        #1;
        check("fl_valid", {31'd0, m_valid}, 32'd0);
        check("fl_bufcnt", {30'd0, buf_cnt}, 32'd0);
        check("fl_rden_hold", {31'd0, rd_en}, 32'd0);
        @(negedge rdclk);
        flush   = 1'b0;
        m_ready = 1'b1;
        #1;
        expect_stream("fl_data", 8'h34, 3);

`ifdef RD_STREAM_WCNT_EN
        // Word counter wrap and clear
        @(negedge rdclk);
        flush = 1'b1;
        @(negedge rdclk);
        flush = 1'b0;
        #1;
        check("wc_clear0", {16'd0, wcnt}, 32'd0);
        for (int i = 0; i < 70000; i++) push(i[7:0]);
        repeat (70010) @(negedge rdclk);
        #1;
        check("wc_wrap", {16'd0, wcnt}, 32'd4464);
        check("wc_drained", {30'd0, buf_cnt}, 32'd0);
        @(negedge rdclk);
        flush = 1'b1;
        @(negedge rdclk);
        flush = 1'b0;
        #1;
        check("wc_clear1", {16'd0, wcnt}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
